// File: rtl/seq_mult16_if.sv
// seq_mult16_if: operand/product handshake bundle for the sequential multiplier.
// master = operand producer / product consumer, slave = multiplier.
interface seq_mult16_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_mult16.sv
// seq_mult16: unsigned shift-and-add multiplier, one WIDTH-bit partial
// product per cycle, 2*WIDTH-bit result behind a valid/ready output.
// Optional macro SEQ_MULT_EARLY_TERM_EN: finish as soon as the remaining
// multiplier bits are all zero (product value is unchanged).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for operands, in_ready=1
// CALC  | one shift/add step per edge, busy=1
// DONE  | product valid, held until out_ready
module seq_mult16 #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_mult16_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_sum;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] mplier_shr;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    product_q;
  logic             out_valid_q;

  logic             accept;
  logic             calc_last;
  logic             drain;

  assign accept     = (state == S_IDLE) && bus.in_valid;
  assign drain      = (state == S_DONE) && bus.out_ready;

  // The product fits in PW bits, so the carry out of this add is always 0.
  assign acc_sum    = mplier[0] ? (acc + mcand) : acc;
  assign mplier_shr = mplier >> 1;

`ifdef SEQ_MULT_EARLY_TERM_EN
  // Stop once no set multiplier bits remain after this step.
  assign calc_last  = (state == S_CALC) &&
                      ((cnt == CNT_LAST) || (mplier_shr == '0));
`else
  assign calc_last  = (state == S_CALC) && (cnt == CNT_LAST);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (calc_last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture and shift/add datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, bus.a};
      mplier <= bus.b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == S_CALC) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier_shr;
      // Hold the count on the final step so it never wraps inside CALC.
      if (!calc_last) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Result register: loaded on completion, kept until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (calc_last) begin
      product_q   <= acc_sum;
      out_valid_q <= 1'b1;
    end else if (drain) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.busy      = (state == S_CALC);
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;

endmodule

// File: tb/tb_seq_mult16.sv
// tb_seq_mult16: directed table, hand-written corner sequences and random
// operands checked against a plain a*b / latency reference.
module tb_seq_mult16;

  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  seq_mult16_if #(.WIDTH(W)) bus ();

  seq_mult16 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] prod;
    int          lat_base;
    int          lat_et;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference latency: edges from acceptance to out_valid.
  function automatic int exp_lat(input logic [15:0] bv);
    int l;
`ifdef SEQ_MULT_EARLY_TERM_EN
    l = 1;
    for (int i = 0; i < W; i++) begin
      if (bv[i]) l = i + 1;
    end
`else
    l = W;
`endif
    return l;
  endfunction

  function automatic logic [31:0] ref_prod(input logic [15:0] av, input logic [15:0] bv);
    return 32'(av) * 32'(bv);
  endfunction

  // One full transaction with out_ready=1; inputs are changed while computing
  // to show they are sampled only on the accepting edge.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv,
                        input logic [31:0] ep, input int el, input string tag);
    int w;
    int lat;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    chk({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
    bus.a = ta; bus.b = tbv; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.a = 16'($urandom); bus.b = 16'($urandom);
    bus.in_valid = 1'($urandom);
    chk({tag, "_busy"}, {62'd0, bus.busy, bus.in_ready}, 64'd2);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      bus.in_valid = 1'($urandom);
      bus.a = 16'($urandom); bus.b = 16'($urandom);
      if (!bus.out_valid) lat++;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'(el));
    chk({tag, "_product"}, 64'(bus.product), 64'(ep));
    @(posedge clk); #1;
    chk({tag, "_drained"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
    chk({tag, "_held"}, 64'(bus.product), 64'(ep));
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] ba;
    logic [15:0] bb;
    logic [31:0] ep;
    int          lat;
    int          el;

    n_vec = 0;
    n_err = 0;
    tbl[0] = '{16'hAB32, 16'h2121, 32'h16278372, 16, 14};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16, 16};
    tbl[2] = '{16'h0000, 16'h0003, 32'h00000000, 16, 2};
    tbl[3] = '{16'h1234, 16'h0001, 32'h00001234, 16, 1};
    tbl[4] = '{16'h0003, 16'h0005, 32'h0000000F, 16, 3};

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("reset_state", {bus.product, 28'd0, bus.out_valid, bus.in_ready, bus.busy, 1'b0},
        {32'd0, 28'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 5; i++) begin
`ifdef SEQ_MULT_EARLY_TERM_EN
      el = tbl[i].lat_et;
`else
      el = tbl[i].lat_base;
`endif
      run_op(tbl[i].a, tbl[i].b, tbl[i].prod, el, $sformatf("tbl%0d", i));
    end

    // Back-pressure: result must hold and new requests must be ignored.
    ba = 16'hF800; bb = 16'hFAAA; ep = ref_prod(ba, bb);
    bus.a = ba; bus.b = bb; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      if (!bus.out_valid) lat++;
    end
    chk("bp_latency", 64'(lat), 64'(exp_lat(bb)));
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1; bus.a = 16'($urandom); bus.b = 16'($urandom);
      @(posedge clk); #1;
      chk("bp_hold", {bus.product, 30'd0, bus.out_valid, bus.in_ready},
          {ep, 30'd0, 1'b1, 1'b0});
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_drain", {bus.product, 30'd0, bus.out_valid, bus.in_ready},
        {ep, 30'd0, 1'b0, 1'b1});

    // Asynchronous reset in the middle of a calculation.
    bus.a = 16'h0800; bus.b = 16'hDAAA; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid", {bus.product, 29'd0, bus.out_valid, bus.busy, bus.in_ready},
        {32'd0, 29'd0, 1'b0, 1'b0, 1'b1});
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h0003, 16'h0005, 32'h0000000F, exp_lat(16'h0005), "post_rst");

    // Back-to-back with in_valid held high: second accept only after drain.
    ra = 16'h1357; rb = 16'h8001; ba = 16'h2468; bb = 16'h00F0;
    bus.a = ra; bus.b = rb; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.a = ba; bus.b = bb;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      if (!bus.out_valid) lat++;
    end
    chk("b2b_first", 64'(bus.product), 64'(ref_prod(ra, rb)));
    @(posedge clk); #1;
    chk("b2b_gap", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("b2b_accept", 64'(bus.busy), 64'd1);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      if (!bus.out_valid) lat++;
    end
    chk("b2b_lat", 64'(lat), 64'(exp_lat(bb)));
    chk("b2b_second", 64'(bus.product), 64'(ref_prod(ba, bb)));
    @(posedge clk); #1;

    // Random operands; multiplier sometimes narrowed to vary its top bit.
    for (int n = 0; n < 40; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom) >> $urandom_range(0, 15);
      if (n % 10 == 0) rb = '0;
      run_op(ra, rb, ref_prod(ra, rb), exp_lat(rb), $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
